// File: rtl/text_cursor_writer_pkg.sv
// Shared grid, ASCII and state definitions for the text cursor writer.
// Optional build macro used by the top: CURSOR_BLINK_EN.
package text_cursor_writer_pkg;

  localparam int CHAR_PX  = 16;
  localparam int DEF_COLS = 640 / CHAR_PX;
  localparam int DEF_ROWS = 480 / CHAR_PX;

  localparam logic [7:0] ASC_SPACE    = 8'h20;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_USCORE   = 8'h5F;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ERASE = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_PRINT_LO) && (c <= ASC_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_cursor_writer_cursor_stepper.sv
// Combinational one-cell step through the grid, row-major, wrapping at both ends.
// prev_i selects a backward step; used for the cursor and for the clear scan.
module text_cursor_writer_cursor_stepper #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic       prev_i,
  input  logic [5:0] x_i,
  input  logic [5:0] y_i,
  output logic [5:0] x_o,
  output logic [5:0] y_o
);

  localparam logic [5:0] XMAX = 6'(COLS - 1);
  localparam logic [5:0] YMAX = 6'(ROWS - 1);

  // Explicit bounds compare: the grid never fills the 6-bit range.
  always_comb begin
    x_o = x_i;
    y_o = y_i;
    if (!prev_i) begin
      if (x_i == XMAX) begin
        x_o = 6'd0;
        y_o = (y_i == YMAX) ? 6'd0 : y_i + 6'd1;
      end else begin
        x_o = x_i + 6'd1;
      end
    end else begin
      if (x_i == 6'd0) begin
        x_o = XMAX;
        y_o = (y_i == 6'd0) ? YMAX : y_i - 6'd1;
      end else begin
        x_o = x_i - 6'd1;
      end
    end
  end

endmodule

// File: rtl/text_cursor_writer.sv
// Keyboard stream -> (ascii_code, input_x, input_y) write triple for the character grid.
// Build macro CURSOR_BLINK_EN adds a blinking underscore cursor and an ERASE state.
module text_cursor_writer
  import text_cursor_writer_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
`ifdef CURSOR_BLINK_EN
  , parameter int BLINK_DIV = 12500000
`endif
) (
  input  logic       FPGA_clock,
  input  logic       iRST_n,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] ascii_code,
  output logic [5:0] input_x,
  output logic [5:0] input_y,
  output logic [5:0] cursor_x,
  output logic [5:0] cursor_y,
  output logic [1:0] state_dbg
);

  localparam logic [5:0] XMAX = 6'(COLS - 1);
  localparam logic [5:0] YMAX = 6'(ROWS - 1);

  state_e     state_q, state_d;
  logic [7:0] ascii_q, ascii_d;
  logic [5:0] in_x_q, in_x_d, in_y_q, in_y_d;
  logic [5:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [5:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d;

  logic       act_en;
  logic [7:0] act_key;
  logic [5:0] cur_step_x, cur_step_y, scan_nx, scan_ny;
  logic       scan_last;

  text_cursor_writer_cursor_stepper #(.COLS(COLS), .ROWS(ROWS)) u_cur_step (
    .prev_i (act_key == ASC_BS),
    .x_i    (cur_x_q),
    .y_i    (cur_y_q),
    .x_o    (cur_step_x),
    .y_o    (cur_step_y)
  );

  text_cursor_writer_cursor_stepper #(.COLS(COLS), .ROWS(ROWS)) u_scan_step (
    .prev_i (1'b0),
    .x_i    (scan_x_q),
    .y_i    (scan_y_q),
    .x_o    (scan_nx),
    .y_o    (scan_ny)
  );

  assign scan_last = (scan_x_q == XMAX) && (scan_y_q == YMAX);

`ifdef CURSOR_BLINK_EN
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  pend_q, pend_d;
  logic        blink_tick;

  assign blink_tick = (blink_cnt_q == 32'(BLINK_DIV - 1));

  // Cursor moves that leave a cell (enter/backspace) are deferred one cycle via ERASE.
  always_comb begin
    act_en  = 1'b0;
    act_key = key_ascii;
    if (state_q == ST_ERASE) begin
      act_en  = !clear_req;
      act_key = pend_q;
    end else if (state_q == ST_IDLE && !clear_req && key_valid) begin
      act_en = is_printable(key_ascii);
    end
  end
`else
  always_comb begin
    act_en  = (state_q == ST_IDLE) && !clear_req && key_valid;
    act_key = key_ascii;
  end
`endif

  always_comb begin
    state_d  = state_q;
    ascii_d  = ascii_q;
    in_x_d   = in_x_q;
    in_y_d   = in_y_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
`ifdef CURSOR_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
`endif

    unique case (state_q)
      ST_CLEAR: begin
        if (clear_req) begin
          scan_x_d = 6'd0;
          scan_y_d = 6'd0;
        end else begin
          ascii_d  = ASC_SPACE;
          in_x_d   = scan_x_q;
          in_y_d   = scan_y_q;
          scan_x_d = scan_nx;
          scan_y_d = scan_ny;
          if (scan_last) begin
            state_d = ST_IDLE;
            cur_x_d = 6'd0;
            cur_y_d = 6'd0;
          end
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d  = ST_CLEAR;
          scan_x_d = 6'd0;
          scan_y_d = 6'd0;
        end
`ifdef CURSOR_BLINK_EN
        else if (key_valid) begin
          // Blink phase restarts "on" after every key; the next tick shows it off.
          blink_cnt_d = 32'd0;
          phase_d     = 1'b1;
          if (key_ascii == ASC_CR || key_ascii == ASC_BS) begin
            state_d = ST_ERASE;
            pend_d  = key_ascii;
            ascii_d = ASC_SPACE;
            in_x_d  = cur_x_q;
            in_y_d  = cur_y_q;
          end
        end else if (blink_tick) begin
          blink_cnt_d = 32'd0;
          phase_d     = !phase_q;
          ascii_d     = phase_q ? ASC_SPACE : ASC_USCORE;
          in_x_d      = cur_x_q;
          in_y_d      = cur_y_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 32'd1;
        end
`endif
      end
      ST_ERASE: begin
        state_d = ST_IDLE;
        if (clear_req) begin
          state_d  = ST_CLEAR;
          scan_x_d = 6'd0;
          scan_y_d = 6'd0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (act_en) begin
      if (is_printable(act_key)) begin
        ascii_d = act_key;
        in_x_d  = cur_x_q;
        in_y_d  = cur_y_q;
        cur_x_d = cur_step_x;
        cur_y_d = cur_step_y;
      end else if (act_key == ASC_CR) begin
        cur_x_d = 6'd0;
        cur_y_d = (cur_y_q == YMAX) ? 6'd0 : cur_y_q + 6'd1;
      end else if (act_key == ASC_BS && (cur_x_q != 6'd0 || cur_y_q != 6'd0)) begin
        cur_x_d = cur_step_x;
        cur_y_d = cur_step_y;
        ascii_d = ASC_SPACE;
        in_x_d  = cur_step_x;
        in_y_d  = cur_step_y;
      end
    end
  end

  // Reset triple uses 8'h00 so the first clear write (0,0,space) is a real change.
  always_ff @(posedge FPGA_clock or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= ST_CLEAR;
      ascii_q  <= 8'h00;
      in_x_q   <= 6'd0;
      in_y_q   <= 6'd0;
      cur_x_q  <= 6'd0;
      cur_y_q  <= 6'd0;
      scan_x_q <= 6'd0;
      scan_y_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      ascii_q  <= ascii_d;
      in_x_q   <= in_x_d;
      in_y_q   <= in_y_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      scan_x_q <= scan_x_d;
      scan_y_q <= scan_y_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  always_ff @(posedge FPGA_clock or negedge iRST_n) begin
    if (!iRST_n) begin
      blink_cnt_q <= 32'd0;
      phase_q     <= 1'b1;
      pend_q      <= 8'h00;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
    end
  end
`endif

  assign busy       = (state_q != ST_IDLE);
  assign ascii_code = ascii_q;
  assign input_x    = in_x_q;
  assign input_y    = in_y_q;
  assign cursor_x   = cur_x_q;
  assign cursor_y   = cur_y_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer: clear sweep, typing, wrap, enter, backspace, clear priority.
module tb_text_cursor_writer;
  import text_cursor_writer_pkg::*;

  // ---------------- clock / reset ----------------
  logic       FPGA_clock = 1'b0;
  logic       iRST_n;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       clear_req;
  logic       busy;
  logic [7:0] ascii_code;
  logic [5:0] input_x, input_y, cursor_x, cursor_y;
  logic [1:0] state_dbg;

  always #5 FPGA_clock = ~FPGA_clock;

  text_cursor_writer dut (
    .FPGA_clock (FPGA_clock),
    .iRST_n     (iRST_n),
    .key_valid  (key_valid),
    .key_ascii  (key_ascii),
    .clear_req  (clear_req),
    .busy       (busy),
    .ascii_code (ascii_code),
    .input_x    (input_x),
    .input_y    (input_y),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errs   = 0;
  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] tri_of(input int x, input int y, input logic [7:0] c);
    return {6'(x), 6'(y), c};
  endfunction

  function automatic logic [19:0] triple_now();
    return {input_x, input_y, ascii_code};
  endfunction

  function automatic logic [11:0] cur_of(input int x, input int y);
    return {6'(x), 6'(y)};
  endfunction

  // ---------------- drivers (entered and left on a negedge) ----------------
  task automatic send_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_ascii = k;
    @(negedge FPGA_clock);
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic send_n(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) send_key(k);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int sweep_errs;
    int busy_cycles;
    int n;
    logic [19:0] e;

    iRST_n    = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    clear_req = 1'b0;
    repeat (3) @(posedge FPGA_clock);
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_triple", triple_now(), tri_of(0, 0, 8'h00));
    check_eq("rst_cursor", {cursor_x, cursor_y}, cur_of(0, 0));
    check_eq("rst_state", state_dbg, ST_CLEAR);

    @(negedge FPGA_clock);
    iRST_n = 1'b1;

    // Full-grid clear sweep, row-major, one cell per cycle.
    for (int i = 0; i < 1200; i++) exp_q.push_back(tri_of(i % 40, i / 40, 8'h20));
    sweep_errs  = 0;
    busy_cycles = 0;
    for (int i = 0; i < 1200; i++) begin
      if (busy) busy_cycles++;
      @(posedge FPGA_clock);
      #1;
      e = exp_q.pop_front();
      if (triple_now() !== e) sweep_errs++;
      @(negedge FPGA_clock);
    end
    check_eq("clear_sweep_errs", sweep_errs, 0);
    check_eq("clear_busy_cycles", busy_cycles, 1200);
    check_eq("clear_done_busy", busy, 0);
    check_eq("clear_done_cursor", {cursor_x, cursor_y}, cur_of(0, 0));
    check_eq("clear_done_state", state_dbg, ST_IDLE);
    check_eq("clear_last_cell", triple_now(), tri_of(39, 29, 8'h20));

    // Printable keys.
    send_key(8'h41);
    check_eq("key_A_triple", triple_now(), tri_of(0, 0, 8'h41));
    send_key(8'h42);
    check_eq("key_B_triple", triple_now(), tri_of(1, 0, 8'h42));
    check_eq("key_B_cursor", {cursor_x, cursor_y}, cur_of(2, 0));

    send_n(8'h78, 37);
    check_eq("fill_row0_cursor", {cursor_x, cursor_y}, cur_of(39, 0));
    send_key(8'h5A);
    check_eq("key_Z_triple", triple_now(), tri_of(39, 0, 8'h5A));
    check_eq("key_Z_cursor_wrap", {cursor_x, cursor_y}, cur_of(0, 1));

    // Backspace across a row boundary.
    send_key(8'h08);
    check_eq("bs_row_triple", triple_now(), tri_of(39, 0, 8'h20));
    check_eq("bs_row_cursor", {cursor_x, cursor_y}, cur_of(39, 0));

    // Non-printable codes are ignored.
    send_key(8'h01);
    send_key(8'h7F);
    send_key(8'h1F);
    check_eq("ignored_triple", triple_now(), tri_of(39, 0, 8'h20));
    check_eq("ignored_cursor", {cursor_x, cursor_y}, cur_of(39, 0));

    // Walk down to the last row and fill it with 8'h7E (upper printable bound).
    send_n(8'h0D, 29);
    check_eq("enter_to_row29", {cursor_x, cursor_y}, cur_of(0, 29));
    send_n(8'h7E, 39);
    check_eq("tilde_triple", triple_now(), tri_of(38, 29, 8'h7E));
    send_key(8'h51);
    check_eq("key_Q_triple", triple_now(), tri_of(39, 29, 8'h51));
    check_eq("key_Q_cursor_wrap", {cursor_x, cursor_y}, cur_of(0, 0));

    send_key(8'h08);
    check_eq("bs_origin_triple", triple_now(), tri_of(39, 29, 8'h51));
    check_eq("bs_origin_cursor", {cursor_x, cursor_y}, cur_of(0, 0));

    // Enter from the middle of a row and from the last row.
    send_n(8'h0D, 3);
    send_n(8'h61, 5);
    check_eq("pos_5_3_cursor", {cursor_x, cursor_y}, cur_of(5, 3));
    send_key(8'h0D);
    check_eq("enter_triple_same", triple_now(), tri_of(4, 3, 8'h61));
    check_eq("enter_cursor", {cursor_x, cursor_y}, cur_of(0, 4));
    send_n(8'h0D, 25);
    check_eq("enter_row29b", {cursor_x, cursor_y}, cur_of(0, 29));
    send_key(8'h0D);
    check_eq("enter_wrap_cursor", {cursor_x, cursor_y}, cur_of(0, 0));

    // Clear and key together: clear wins, scan restarts at (0,0).
    key_valid = 1'b1;
    key_ascii = 8'h4B;
    clear_req = 1'b1;
    @(negedge FPGA_clock);
    key_valid = 1'b0;
    key_ascii = 8'h00;
    clear_req = 1'b0;
    check_eq("clr_key_busy", busy, 1);
    check_eq("clr_key_triple", triple_now(), tri_of(4, 3, 8'h61));
    @(negedge FPGA_clock);
    check_eq("clr_first_cell", triple_now(), tri_of(0, 0, 8'h20));
    @(negedge FPGA_clock);
    check_eq("clr_second_cell", triple_now(), tri_of(1, 0, 8'h20));

    // Key during CLEAR does not disturb the scan.
    send_key(8'h58);
    check_eq("clr_key_ignored", triple_now(), tri_of(2, 0, 8'h20));
    check_eq("clr_key_cursor", {cursor_x, cursor_y}, cur_of(0, 0));

    // clear_req during CLEAR restarts the scan.
    clear_req = 1'b1;
    @(negedge FPGA_clock);
    clear_req = 1'b0;
    check_eq("restart_hold", triple_now(), tri_of(2, 0, 8'h20));
    @(negedge FPGA_clock);
    check_eq("restart_cell0", triple_now(), tri_of(0, 0, 8'h20));
    n = 0;
    while (busy && n < 1300) begin
      @(negedge FPGA_clock);
      n++;
    end
    check_eq("restart_remaining", n, 1199);
    check_eq("restart_last_cell", triple_now(), tri_of(39, 29, 8'h20));
    check_eq("restart_cursor", {cursor_x, cursor_y}, cur_of(0, 0));

    send_key(8'h43);
    check_eq("post_clear_key", triple_now(), tri_of(0, 0, 8'h43));
    check_eq("post_clear_cursor", {cursor_x, cursor_y}, cur_of(1, 0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream stage of vga_controller. Turns a keyboard character stream into the (ascii_code, input_x, input_y) write triple that feeds the character-grid memory.
- The display side writes whenever any field of the triple changes, so this block changes character and position together in a single cycle.
- Owns the cursor and handles newline and backspace.
- Clears the grid after reset and on request.

Parameters:
- COLS, 40, grid columns (640/16).
- ROWS, 30, grid rows (480/16).
- BLINK_DIV, 12500000, FPGA_clock cycles per cursor blink phase (used only with the optional feature).

Ports:
- FPGA_clock  in  1  system clock; all logic on its rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_ascii is valid in this cycle.
- key_ascii  in  8  ASCII code of the key.
- clear_req  in  1  level or pulse; starts a full-grid clear.
- busy  out  1  high while clearing or while a multi-write op is pending; keys are dropped while high.
- ascii_code  out  8  character to write; drives vga_controller.ascii_code.
- input_x  out  6  write column; drives vga_controller.input_x.
- input_y  out  6  write row; drives vga_controller.input_y.
- cursor_x  out  6  current cursor column.
- cursor_y  out  6  current cursor row.

Behaviour:
- Reset (asynchronous, iRST_n low): ascii_code=8'h00, input_x=0, input_y=0, cursor=(0,0), state=CLEAR, clear counter=(0,0), busy=1.
  - 8'h00 is deliberate. The first clear write is (0,0,8'h20), which differs from the reset triple, so cell (0,0) is actually written.
- Write invariant: every output update changes at least one triple field, or repeats a triple the grid memory already holds. Each register update is one memory write on the next clock.
- States:
  - CLEAR:
    - Each cycle outputs (cx,cy,8'h20), scanning row-major from (0,0) to (COLS-1,ROWS-1): exactly COLS*ROWS cycles (1200 by default).
    - After the last cell: cursor=(0,0), go to IDLE, busy=0.
    - key_valid is ignored.
    - clear_req seen during CLEAR restarts the counter at (0,0).
  - IDLE: busy=0. When key_valid=1 the key takes effect at the same edge (outputs valid after the edge, so latency is 1 cycle):
    - Printable 8'h20..8'h7E: triple=(cursor, key). Cursor advances: x+1; at x=COLS-1 go to x=0, y+1; at (COLS-1,ROWS-1) wrap to (0,0). There is no scrolling.
    - 8'h0D (enter): cursor=(0, y+1); y=ROWS-1 wraps to row 0. No write.
    - 8'h08 (backspace): cursor steps back (x-1; x=0 goes to (COLS-1, y-1)); then triple=(new cursor, 8'h20). At (0,0): no-op, no write.
    - Any other code: ignored.
  - clear_req in IDLE: go to CLEAR. If clear_req and key_valid arrive in the same cycle, clear wins and the key is dropped.
- Arithmetic: positions are 6-bit unsigned. Comparisons are against COLS-1 and ROWS-1; never rely on natural 6-bit wrap.
- Reset mid-clear: restarts the clear from (0,0).

Optional Feature:
- Macro CURSOR_BLINK_EN.
- Defined:
  - A BLINK_DIV counter toggles phase. In IDLE with no key, each phase edge writes (cursor, 8'h5F '_') or (cursor, 8'h20).
  - A key in the same cycle has priority; the blink write is skipped that phase.
  - Any cursor move (printable, enter, backspace) first leaves the old cursor cell without an underscore:
    - Enter and backspace enter state ERASE for 1 cycle (busy=1) and write (old cursor, 8'h20) before the normal action.
    - Printable overwrites the cell directly.
  - The blink phase resets to "on" after each key.
- Undefined: no counter, no ERASE state, and busy is high only during CLEAR.

Decomposition:
- Shared include text_grid_defs.vh:
  - Grid constants: COLS, ROWS, CHAR_PX=16.
  - ASCII constants: ASC_SPACE=8'h20, ASC_BS=8'h08, ASC_CR=8'h0D, ASC_USCORE=8'h5F, printable bounds.
  - State encodings: CLEAR, IDLE, ERASE.
- One sub-module, cursor_stepper: combinational next/previous (x,y) with wrap, used for both the cursor and the clear scan.

Test Plan:
- Reset release -> busy=1 for exactly 1200 cycles. Triples sweep (0,0,20)..(39,29,20) row-major with one change per cycle. Then busy=0 and cursor=(0,0).
- After clear, key 'A'(41) then 'B'(42) -> triples (0,0,41), then (1,0,42); cursor=(2,0).
- Cursor at (39,0), key 'Z' -> triple (39,0,5A); cursor=(0,1). At (39,29), key 'Q' -> cursor=(0,0).
- Cursor (0,1), backspace -> triple (39,0,20); cursor=(39,0). At (0,0), backspace -> no output change.
- Cursor (5,3), enter -> outputs unchanged, cursor=(0,4). At row 29, enter -> cursor=(0,0).
- key_valid and clear_req asserted in the same cycle in IDLE -> key dropped, CLEAR restarts at (0,0). Key asserted during CLEAR -> ignored, no triple change outside the scan.
